// File: rtl/sys_bus_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sys_bus_master : burst initiator driving word writes/reads into a register
// slave. Define BUS_MASTER_VERIFY_EN to read back and compare every write.
// Revision: 1.0
// ---------------------------------------------------------------------------
module sys_bus_master #(
  parameter logic [31:0] ADDR_BASE   = 32'h4060_0000,
  parameter int          LEN_W       = 6,
  parameter int          ACK_TIMEOUT = 64
) (
  input  logic             clk_100mhz,
  input  logic             rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [19:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [31:0]      wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [31:0]      sys_addr,
  output logic [31:0]      sys_wdata,
  output logic [3:0]       sys_sel,
  output logic             sys_wen,
  output logic             sys_ren,
  input  logic [31:0]      sys_rdata,
  input  logic             sys_err,
  input  logic             sys_ack,
  output logic             done_o,
  output logic             err_o,
  output logic             busy_o
);

  localparam int               TMO_W    = $clog2(ACK_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    ISSUE    = 3'd2,
    WAIT_ACK = 3'd3,
    PUSH     = 3'd4,
`ifdef BUS_MASTER_VERIFY_EN
    VISSUE   = 3'd6,
    VWAIT    = 3'd7,
`endif
    FINISH   = 3'd5
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_write;
  logic [17:0]      r_off;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_idx;
  logic [TMO_W-1:0] r_tmo;
  logic             r_abort;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;

  logic             w_accept;
  logic             w_idx_inc;
  logic             w_abort_set;
  logic             w_rd_cap;
  logic             w_last;
  logic             w_tmo_hit;
  logic             w_waiting;
  logic             w_strobe;
  logic             w_load_addr;
  logic [17:0]      w_issue_word;
  logic             w_unused_lsb;

  assign w_unused_lsb = ^cmd_addr[1:0];
  assign w_last       = (r_idx + LEN_W'(1)) == r_len;
  assign w_tmo_hit    = r_tmo == TMO_LAST;

  always_ff @(posedge clk_100mhz) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_idx_inc   = 1'b0;
    w_abort_set = 1'b0;
    w_rd_cap    = 1'b0;
    w_waiting   = 1'b0;
    case (r_state)
      IDLE: if (cmd_valid) begin
        w_accept = 1'b1;
        if (cmd_len == '0)  w_state_nxt = FINISH;
        else if (cmd_write) w_state_nxt = FETCH;
        else                w_state_nxt = ISSUE;
      end
      FETCH: if (wr_valid) w_state_nxt = ISSUE;
      ISSUE: w_state_nxt = WAIT_ACK;
      WAIT_ACK: begin
        w_waiting = 1'b1;
        if (sys_ack) begin
          if (sys_err) begin
            w_abort_set = 1'b1;
            w_state_nxt = FINISH;
          end else if (!r_write) begin
            w_rd_cap    = 1'b1;
            w_state_nxt = PUSH;
          end else begin
`ifdef BUS_MASTER_VERIFY_EN
            w_state_nxt = VISSUE;
`else
            w_idx_inc   = 1'b1;
            w_state_nxt = w_last ? FINISH : FETCH;
`endif
          end
        end else if (w_tmo_hit) begin
          w_abort_set = 1'b1;
          w_state_nxt = FINISH;
        end
      end
      PUSH: if (rd_ready) begin
        w_idx_inc   = 1'b1;
        w_state_nxt = w_last ? FINISH : ISSUE;
      end
`ifdef BUS_MASTER_VERIFY_EN
      VISSUE: w_state_nxt = VWAIT;
      VWAIT: begin
        w_waiting = 1'b1;
        if (sys_ack) begin
          if (sys_err || (sys_rdata != r_wdata)) begin
            w_abort_set = 1'b1;
            w_state_nxt = FINISH;
          end else begin
            w_idx_inc   = 1'b1;
            w_state_nxt = w_last ? FINISH : FETCH;
          end
        end else if (w_tmo_hit) begin
          w_abort_set = 1'b1;
          w_state_nxt = FINISH;
        end
      end
`endif
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The word about to be strobed; a PUSH handshake moves on to the next index.
  always_comb begin
    if (r_state == IDLE) w_issue_word = cmd_addr[19:2];
    else                 w_issue_word = r_off + 18'(r_idx) + ((r_state == PUSH) ? 18'd1 : 18'd0);
  end

  assign w_load_addr = (w_state_nxt == ISSUE) && (r_state != ISSUE);

  always_ff @(posedge clk_100mhz) begin
    if (rst_i) begin
      r_write <= 1'b0;
      r_off   <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_tmo   <= '0;
      r_abort <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_accept) begin
        r_write <= cmd_write;
        r_off   <= cmd_addr[19:2];
        r_len   <= cmd_len;
        r_idx   <= '0;
        r_abort <= 1'b0;
      end else if (w_idx_inc) begin
        r_idx <= r_idx + LEN_W'(1);
      end
      if (w_abort_set)                     r_abort <= 1'b1;
      if (w_load_addr)                     r_addr  <= {ADDR_BASE[31:20], w_issue_word, 2'b00};
      if ((r_state == FETCH) && wr_valid)  r_wdata <= wr_data;
      if (w_rd_cap)                        r_rdata <= sys_rdata;
      r_tmo <= w_waiting ? r_tmo + TMO_W'(1) : '0;
    end
  end

`ifdef BUS_MASTER_VERIFY_EN
  assign sys_ren = ((r_state == ISSUE) && !r_write) || (r_state == VISSUE);
`else
  assign sys_ren = (r_state == ISSUE) && !r_write;
`endif
  assign sys_wen   = (r_state == ISSUE) && r_write;
  assign w_strobe  = sys_wen || sys_ren;
  assign sys_sel   = w_strobe ? 4'hF : 4'h0;
  assign sys_addr  = r_addr;
  assign sys_wdata = r_wdata;
  assign rd_data   = r_rdata;
  assign rd_valid  = r_state == PUSH;
  assign wr_ready  = r_state == FETCH;
  assign cmd_ready = r_state == IDLE;
  assign busy_o    = r_state != IDLE;
  assign done_o    = r_state == FINISH;
  assign err_o     = (r_state == FINISH) && r_abort;

endmodule
`default_nettype wire
